// File: rtl/mem_ctrl_pkg.sv
// Shared cache/main-memory types plus the memory controller's FSM and owner encodings.
// Types only; no logic, latency or flow control lives here.
// Imported by every mem_ctrl file and by the caches that talk to it.
package global_defs;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  localparam int MAIN_MEM_BLOCK_ADDR_WIDTH = 28;
  localparam int BLOCK_DATA_WIDTH          = 64;

  typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_ctrl_state_t;

  typedef enum logic {
    ICACHE_OWNER = 1'b0,
    DCACHE_OWNER = 1'b1
  } mem_ctrl_owner_t;

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Picks icache or dcache for the main-memory port; icache favoured, dcache wins after STARVE_LIMIT.
// Latency: grants are combinational in the same cycle; the starvation counter updates on the clock.
// Backpressure: grants only while idle; an unserved requester just keeps valid high.
module mem_ctrl_arbiter
  import global_defs::*;
#(
  parameter int STARVE_LIMIT     = 4,
  parameter int STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic icache_req_valid,
  input  logic dcache_req_valid,
  output logic grant_i,
  output logic grant_d
);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt;
  logic                        starved;

  assign starved = (starve_cnt == STARVE_CNT_WIDTH'(STARVE_LIMIT));
  assign grant_i = idle & icache_req_valid & ~(starved & dcache_req_valid);
  assign grant_d = idle & dcache_req_valid & (~icache_req_valid | starved);

  // grant_i with dcache waiting implies not starved, so the count saturates at STARVE_LIMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_d || (idle && !dcache_req_valid)) begin
      starve_cnt <= '0;
    end else if (grant_i && dcache_req_valid && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Funnels icache/dcache block requests onto one main-memory port, one transaction in flight.
// Latency: grant -> ISSUE next cycle; response pulse one cycle after main_mem_resp_valid.
// Backpressure: cache readies stay low outside IDLE; ISSUE holds until main_mem_req_ready.
module mem_ctrl
  import global_defs::*;
#(
  parameter int STARVE_LIMIT     = 4,
  parameter int STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 icache_req_valid,
  input  req_type_t            icache_req_type,
  input  main_mem_block_addr_t icache_req_block_addr,
  input  block_data_t          icache_req_block_data,
  output logic                 icache_req_ready,
  output logic                 icache_resp_valid,
  output block_data_t          icache_resp_block_data,

  input  logic                 dcache_req_valid,
  input  req_type_t            dcache_req_type,
  input  main_mem_block_addr_t dcache_req_block_addr,
  input  block_data_t          dcache_req_block_data,
  output logic                 dcache_req_ready,
  output logic                 dcache_resp_valid,
  output block_data_t          dcache_resp_block_data,

  output logic                 main_mem_req_valid,
  output req_type_t            main_mem_req_type,
  output main_mem_block_addr_t main_mem_req_block_addr,
  output block_data_t          main_mem_req_block_data,
  input  logic                 main_mem_req_ready,
  input  logic                 main_mem_resp_valid,
  input  block_data_t          main_mem_resp_block_data
);

  mem_ctrl_state_t      state, state_nxt;
  mem_ctrl_owner_t      owner;
  req_type_t            req_type_q;
  main_mem_block_addr_t req_addr_q;
  block_data_t          req_data_q;
  block_data_t          resp_data_q;
  logic                 idle;
  logic                 grant_i, grant_d;

  // readies must read 0 while reset is held, even though state already shows IDLE
  assign idle = (state == IDLE) & ~rst;

  mem_ctrl_arbiter #(
    .STARVE_LIMIT    (STARVE_LIMIT),
    .STARVE_CNT_WIDTH(STARVE_CNT_WIDTH)
  ) u_arbiter (
    .clk             (clk),
    .rst             (rst),
    .idle            (idle),
    .icache_req_valid(icache_req_valid),
    .dcache_req_valid(dcache_req_valid),
    .grant_i         (grant_i),
    .grant_d         (grant_d)
  );

  assign icache_req_ready = grant_i;
  assign dcache_req_ready = grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = ISSUE;
      ISSUE:   if (main_mem_req_ready) state_nxt = WAIT;
      WAIT:    if (main_mem_resp_valid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner       <= ICACHE_OWNER;
      req_type_q  <= READ;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      resp_data_q <= '0;
    end else begin
      if (grant_i || grant_d) begin
        owner      <= grant_d ? DCACHE_OWNER : ICACHE_OWNER;
        req_type_q <= grant_d ? dcache_req_type : icache_req_type;
        req_addr_q <= grant_d ? dcache_req_block_addr : icache_req_block_addr;
        req_data_q <= grant_d ? dcache_req_block_data : icache_req_block_data;
      end
      // writes echo the sent data so the cache refill stays consistent with memory
      if (state == WAIT && main_mem_resp_valid) begin
        resp_data_q <= (req_type_q == WRITE) ? req_data_q : main_mem_resp_block_data;
      end
    end
  end

  assign main_mem_req_valid      = (state == ISSUE);
  assign main_mem_req_type       = req_type_q;
  assign main_mem_req_block_addr = req_addr_q;
  assign main_mem_req_block_data = req_data_q;

  assign icache_resp_valid      = (state == RESP) && (owner == ICACHE_OWNER);
  assign dcache_resp_valid      = (state == RESP) && (owner == DCACHE_OWNER);
  assign icache_resp_block_data = resp_data_q;
  assign dcache_resp_block_data = resp_data_q;

  a_one_ready: assert property (@(posedge clk) disable iff (rst)
    !(icache_req_ready && dcache_req_ready));
  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    !(icache_resp_valid && dcache_resp_valid));
  a_resp_in_resp: assert property (@(posedge clk) disable iff (rst)
    (icache_resp_valid || dcache_resp_valid) |-> (state == RESP));
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (main_mem_req_valid && !main_mem_req_ready) |=>
      (main_mem_req_valid && $stable(main_mem_req_type) &&
       $stable(main_mem_req_block_addr) && $stable(main_mem_req_block_data)));

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers feed request queues, a memory model answers,
// monitors pop expected grants/responses and compare.
module tb_mem_ctrl;
  import global_defs::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 icache_req_valid, icache_req_ready, icache_resp_valid;
  req_type_t            icache_req_type;
  main_mem_block_addr_t icache_req_block_addr;
  block_data_t          icache_req_block_data, icache_resp_block_data;
  logic                 dcache_req_valid, dcache_req_ready, dcache_resp_valid;
  req_type_t            dcache_req_type;
  main_mem_block_addr_t dcache_req_block_addr;
  block_data_t          dcache_req_block_data, dcache_resp_block_data;
  logic                 main_mem_req_valid, main_mem_req_ready, main_mem_resp_valid;
  req_type_t            main_mem_req_type;
  main_mem_block_addr_t main_mem_req_block_addr;
  block_data_t          main_mem_req_block_data, main_mem_resp_block_data;

  always #5 clk = ~clk;

  mem_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .icache_req_valid        (icache_req_valid),
    .icache_req_type         (icache_req_type),
    .icache_req_block_addr   (icache_req_block_addr),
    .icache_req_block_data   (icache_req_block_data),
    .icache_req_ready        (icache_req_ready),
    .icache_resp_valid       (icache_resp_valid),
    .icache_resp_block_data  (icache_resp_block_data),
    .dcache_req_valid        (dcache_req_valid),
    .dcache_req_type         (dcache_req_type),
    .dcache_req_block_addr   (dcache_req_block_addr),
    .dcache_req_block_data   (dcache_req_block_data),
    .dcache_req_ready        (dcache_req_ready),
    .dcache_resp_valid       (dcache_resp_valid),
    .dcache_resp_block_data  (dcache_resp_block_data),
    .main_mem_req_valid      (main_mem_req_valid),
    .main_mem_req_type       (main_mem_req_type),
    .main_mem_req_block_addr (main_mem_req_block_addr),
    .main_mem_req_block_data (main_mem_req_block_data),
    .main_mem_req_ready      (main_mem_req_ready),
    .main_mem_resp_valid     (main_mem_resp_valid),
    .main_mem_resp_block_data(main_mem_resp_block_data)
  );

  typedef struct {
    main_mem_block_addr_t addr;
    req_type_t            t;
    block_data_t          data;
  } req_t;

  typedef struct {
    bit          d;
    block_data_t data;
  } resp_t;

  req_t        iq[$];
  req_t        dq[$];
  resp_t       exp_resp[$];
  bit          exp_grant[$];
  resp_t       mon_r;
  bit          inflight = 1'b0;
  bit          i_manual = 1'b0;
  int          mm_stall = 0;
  int          mm_lat   = 2;
  int          checks   = 0;
  int          failures = 0;
  block_data_t mem_rd[main_mem_block_addr_t];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || exp_resp.size() != 0 || inflight) && n < 300) begin
      @(negedge clk); #3;
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0 || exp_resp.size() != 0 || inflight) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=busy expected=idle", name);
    end
  endtask

  // icache driver: presents the queue head until it is granted
  initial begin
    icache_req_valid = 1'b0; icache_req_type = READ;
    icache_req_block_addr = '0; icache_req_block_data = '0;
    forever begin
      @(negedge clk);
      if (!i_manual) begin
        if (iq.size() > 0) begin
          icache_req_valid      = 1'b1;
          icache_req_type       = iq[0].t;
          icache_req_block_addr = iq[0].addr;
          icache_req_block_data = iq[0].data;
        end else begin
          icache_req_valid = 1'b0;
        end
        #1;
        if (icache_req_valid && icache_req_ready) void'(iq.pop_front());
      end
    end
  end

  initial begin
    dcache_req_valid = 1'b0; dcache_req_type = READ;
    dcache_req_block_addr = '0; dcache_req_block_data = '0;
    forever begin
      @(negedge clk);
      if (dq.size() > 0) begin
        dcache_req_valid      = 1'b1;
        dcache_req_type       = dq[0].t;
        dcache_req_block_addr = dq[0].addr;
        dcache_req_block_data = dq[0].data;
      end else begin
        dcache_req_valid = 1'b0;
      end
      #1;
      if (dcache_req_valid && dcache_req_ready) void'(dq.pop_front());
    end
  end

  // main memory: optional ready stall, then a response mm_lat cycles after the handshake
  initial begin
    req_type_t            cap_t;
    main_mem_block_addr_t cap_a;
    main_mem_req_ready = 1'b0; main_mem_resp_valid = 1'b0; main_mem_resp_block_data = '0;
    forever begin
      @(negedge clk);
      main_mem_req_ready  = 1'b0;
      main_mem_resp_valid = 1'b0;
      if (main_mem_req_valid && !rst) begin
        repeat (mm_stall) @(negedge clk);
        main_mem_req_ready = 1'b1;
        cap_t = main_mem_req_type;
        cap_a = main_mem_req_block_addr;
        repeat (mm_lat) begin
          @(negedge clk);
          main_mem_req_ready = 1'b0;
        end
        main_mem_resp_valid = 1'b1;
        if (cap_t == WRITE)          main_mem_resp_block_data = 64'hBAD0_BAD0_BAD0_BAD0;
        else if (mem_rd.exists(cap_a)) main_mem_resp_block_data = mem_rd[cap_a];
        else                         main_mem_resp_block_data = '0;
      end
    end
  end

  // grant and response monitor
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (icache_req_ready || dcache_req_ready) begin
        check("one_ready", {63'd0, icache_req_ready & dcache_req_ready}, 64'd0);
        check("grant_while_busy", {63'd0, inflight}, 64'd0);
        if (exp_grant.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant actual=dcache:%0d expected=none", dcache_req_ready);
        end else begin
          check("grant_owner", {63'd0, dcache_req_ready}, {63'd0, exp_grant.pop_front()});
        end
        inflight = 1'b1;
      end
      if (icache_resp_valid || dcache_resp_valid) begin
        check("one_resp", {63'd0, icache_resp_valid & dcache_resp_valid}, 64'd0);
        if (exp_resp.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp actual=dcache:%0d expected=none", dcache_resp_valid);
        end else begin
          mon_r = exp_resp.pop_front();
          check("resp_owner", {63'd0, dcache_resp_valid}, {63'd0, mon_r.d});
          check("resp_data", mon_r.d ? dcache_resp_block_data : icache_resp_block_data, mon_r.data);
        end
        inflight = 1'b0;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    mem_rd[28'h0000040] = 64'hDEADBEEF_CAFEF00D;
    mem_rd[28'h0000010] = 64'h1010_1010_1010_1010;
    mem_rd[28'h0000300] = 64'h6666_0000_0000_0300;
    for (int k = 0; k < 8; k++) mem_rd[28'h100 + 28'(k)] = 64'h3000_0000_0000_0000 + 64'(k);
    for (int k = 0; k < 2; k++) mem_rd[28'h200 + 28'(k)] = 64'h4000_0000_0000_0000 + 64'(k);

    #1;
    check("rst_icache_ready", {63'd0, icache_req_ready}, 64'd0);
    check("rst_dcache_ready", {63'd0, dcache_req_ready}, 64'd0);
    check("rst_mm_req_valid", {63'd0, main_mem_req_valid}, 64'd0);
    check("rst_resp_valids", {62'd0, icache_resp_valid, dcache_resp_valid}, 64'd0);
    check("rst_resp_data", icache_resp_block_data, 64'd0);
    check("rst_mm_addr", {36'd0, main_mem_req_block_addr}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #3;

    // 1: single icache read
    iq.push_back('{28'h0000040, READ, 64'd0});
    exp_grant.push_back(1'b0);
    exp_resp.push_back('{1'b0, 64'hDEADBEEF_CAFEF00D});
    wait_idle("t1");

    // 2: simultaneous requests, icache first, dcache write echoes its data
    iq.push_back('{28'h0000010, READ, 64'd0});
    dq.push_back('{28'h0000020, WRITE, 64'h11223344_55667788});
    exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
    exp_resp.push_back('{1'b0, 64'h1010_1010_1010_1010});
    exp_resp.push_back('{1'b1, 64'h11223344_55667788});
    wait_idle("t2");

    // 3: starvation: I x4, D, I x4, D (second D proves the counter cleared)
    for (int k = 0; k < 8; k++) iq.push_back('{28'h100 + 28'(k), READ, 64'd0});
    for (int k = 0; k < 2; k++) dq.push_back('{28'h200 + 28'(k), READ, 64'd0});
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        exp_grant.push_back(1'b0);
        exp_resp.push_back('{1'b0, 64'h3000_0000_0000_0000 + 64'(g * 4 + k)});
      end
      exp_grant.push_back(1'b1);
      exp_resp.push_back('{1'b1, 64'h4000_0000_0000_0000 + 64'(g)});
    end
    wait_idle("t3");

    // 4: memory stalls ISSUE for 5 cycles; request fields must hold, no grant meanwhile
    mm_stall = 5;
    dq.push_back('{28'h0000123, WRITE, 64'hCAFE_0000_0000_0123});
    exp_grant.push_back(1'b1);
    exp_resp.push_back('{1'b1, 64'hCAFE_0000_0000_0123});
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!main_mem_req_valid && n < 50);
    iq.push_back('{28'h0000040, READ, 64'd0});
    exp_grant.push_back(1'b0);
    exp_resp.push_back('{1'b0, 64'hDEADBEEF_CAFEF00D});
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #3; end
      check("t4_valid", {63'd0, main_mem_req_valid}, 64'd1);
      check("t4_type", {63'd0, main_mem_req_type}, {63'd0, WRITE});
      check("t4_addr", {36'd0, main_mem_req_block_addr}, 64'h123);
      check("t4_data", main_mem_req_block_data, 64'hCAFE_0000_0000_0123);
    end
    wait_idle("t4");
    mm_stall = 0;

    // 5: reset during WAIT, late response dropped, fresh grant right after
    mm_lat = 4;
    iq.push_back('{28'h0000040, READ, 64'd0});
    exp_grant.push_back(1'b0);
    exp_resp.push_back('{1'b0, 64'hDEADBEEF_CAFEF00D});
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!main_mem_req_ready && n < 50);
    check("t5_handshake_seen", {63'd0, main_mem_req_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_resp.delete();
    inflight = 1'b0;
    #1;
    check("t5_rst_readies", {62'd0, icache_req_ready, dcache_req_ready}, 64'd0);
    check("t5_rst_resp_valids", {62'd0, icache_resp_valid, dcache_resp_valid}, 64'd0);
    check("t5_rst_mm_valid", {63'd0, main_mem_req_valid}, 64'd0);
    check("t5_rst_mm_addr", {36'd0, main_mem_req_block_addr}, 64'd0);
    check("t5_rst_resp_data", icache_resp_block_data, 64'd0);
    check("t5_rst_dresp_data", dcache_resp_block_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    mm_lat = 2;
    iq.push_back('{28'h0000010, READ, 64'd0});
    exp_grant.push_back(1'b0);
    exp_resp.push_back('{1'b0, 64'h1010_1010_1010_1010});
    @(negedge clk); #2;
    check("t5_fresh_grant", {63'd0, icache_req_ready}, 64'd1);
    wait_idle("t5");

    // 6: icache valid raised then dropped while dcache owns memory
    mm_lat = 3;
    dq.push_back('{28'h0000300, READ, 64'd0});
    exp_grant.push_back(1'b1);
    exp_resp.push_back('{1'b1, 64'h6666_0000_0000_0300});
    n = 0;
    do begin @(negedge clk); #3; n++; end while (!inflight && n < 50);
    check("t6_dcache_granted", {63'd0, inflight}, 64'd1);
    @(negedge clk);
    i_manual              = 1'b1;
    icache_req_valid      = 1'b1;
    icache_req_type       = READ;
    icache_req_block_addr = 28'h0000040;
    @(negedge clk);
    @(negedge clk);
    icache_req_valid = 1'b0;
    i_manual         = 1'b0;
    wait_idle("t6");
    repeat (5) @(negedge clk);
    #3;
    check("end_grants_left", 64'(exp_grant.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
